// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and default access latency for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam int LAT_DEF = 1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: picks the first set request bit scanning from ptr upward, modulo C
module rr_pick #(
  parameter int C  = 2,
  parameter int PW = 1
) (
  input  logic [C-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          valid
);
  always_comb begin
    win = '0;
    for (int i = C - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % C]) win = PW'((int'(ptr) + i) % C);
  end
  assign valid = |req;
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one synchronous-read data memory among C cores
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int C   = 2,
  parameter int LAT = LAT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [C-1:0] req,
  input  logic [C-1:0] req_we,
  input  logic [15:0]  req_adr [C],
  input  logic [15:0]  req_wdat [C],
  output logic [C-1:0] ack,
  output logic [15:0]  rdat,
  output logic [15:0]  mem_adr,
  output logic [15:0]  mem_wdat,
  output logic         mem_we,
  input  logic [15:0]  mem_rdat,
  output logic         busy
);
  localparam int PW = C > 1 ? $clog2(C) : 1;
  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, win;
  logic          valid, we_q, we_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   adr_q, adr_d, wdat_q, wdat_d;
  rr_pick #(.C(C), .PW(PW)) u_pick (.req(req), .ptr(ptr_q), .win(win), .valid(valid));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = ACCESS;
        g_d     = win;
        we_d    = req_we[win];
        adr_d   = req_adr[win];
        wdat_d  = req_wdat[win];
        ptr_d   = int'(win) == C - 1 ? '0 : win + PW'(1);
        cnt_d   = '0;
      end
      ACCESS: begin
        state_d = cnt_q == 4'(LAT - 1) ? RESP : ACCESS;
        cnt_d   = cnt_q == 4'(LAT - 1) ? '0 : cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
    end
  end
  // address stays on the bus through RESP so the synchronous read data lines up with ack
  always_comb begin
    busy     = state_q != IDLE;
    mem_we   = state_q == ACCESS && we_q;
    mem_adr  = state_q == IDLE ? '0 : adr_q;
    mem_wdat = state_q == ACCESS ? wdat_q : '0;
    ack      = state_q == RESP ? C'(1) << g_q : '0;
    rdat     = state_q == RESP && !we_q ? mem_rdat : '0;
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed checks of arbitration, latency, reset and idle behaviour
module tb_mem_rr_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  req = '0, we = '0;
  logic [15:0] adr [2], wdat [2];
  logic [1:0]  ack, ack3;
  logic [15:0] rdat, mem_adr, mem_wdat, mem_rdat, rdat3, mem_adr3, mem_wdat3, mem_rdat3;
  logic        mem_we, busy, mem_we3, busy3;
  logic [15:0] mem [256];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_rr_arbiter #(.C(2), .LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(we), .req_adr(adr), .req_wdat(wdat),
    .ack(ack), .rdat(rdat), .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_we(mem_we),
    .mem_rdat(mem_rdat), .busy(busy));
  mem_rr_arbiter #(.C(2), .LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .req_we(we), .req_adr(adr), .req_wdat(wdat),
    .ack(ack3), .rdat(rdat3), .mem_adr(mem_adr3), .mem_wdat(mem_wdat3), .mem_we(mem_we3),
    .mem_rdat(mem_rdat3), .busy(busy3));
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr[7:0]] <= mem_wdat;
    mem_rdat <= mem[mem_adr[7:0]];
    mem_rdat3 <= mem_adr3 ^ 16'h5A5A;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_outs", {ack, mem_we, mem_adr, mem_wdat, rdat}, 0);
    req = 2'b01; we = 2'b01; adr[0] = 16'h0010; wdat[0] = 16'hBEEF;
    step();
    check("wr_we", mem_we, 1);
    check("wr_adr", mem_adr, 16'h0010);
    check("wr_dat", mem_wdat, 16'hBEEF);
    check("wr_busy", busy, 1);
    step();
    check("wr_ack", ack, 2'b01);
    check("wr_resp_we", mem_we, 0);
    check("wr_rdat0", rdat, 0);
    req = 2'b00;
    step();
    check("wr_idle", {busy, ack}, 0);
    req = 2'b01; we = 2'b00;
    step();
    check("rd_we", mem_we, 0);
    step();
    check("rd_ack", ack, 2'b01);
    check("rd_dat", rdat, 16'hBEEF);
    req = 2'b00;
    step();
    check("rd_idle_rdat", rdat, 0);
    req = 2'b11; we = 2'b00; adr[0] = 16'h0001; adr[1] = 16'h0002;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_access_ack", ack, 0);
      check("rr_adr", mem_adr, k % 2 ? 16'h0002 : 16'h0001);
      step();
      check("rr_ack", ack, k % 2 ? 2'b10 : 2'b01);
      step();
      check("rr_idle", {busy, ack}, 0);
    end
    req = 2'b00;
    do_reset();
    req = 2'b10;
    step();
    check("da_busy", busy, 1);
    req = 2'b00;
    step();
    check("da_ack", ack, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step();
      check("da_no_more", {busy, ack}, 0);
    end
    req = 2'b01; we = 2'b01; adr[0] = 16'h0030; wdat[0] = 16'h1234;
    step();
    check("mr_we", mem_we, 1);
    reset = 1'b1;
    req = 2'b00;
    step();
    check("mr_after", {busy, ack, mem_we}, 0);
    reset = 1'b0; req = 2'b11; we = 2'b00;
    step();
    check("mr_busy", busy, 1);
    step();
    check("mr_ptr0", ack, 2'b01);
    req = 2'b00;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_quiet", {busy, ack, mem_we}, 0);
    end
    do_reset();
    adr[0] = 16'h0020; we = 2'b00; req = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("l3_adr", mem_adr3, 16'h0020);
      check("l3_noack", {busy3, ack3}, 3'b100);
    end
    step();
    check("l3_ack", ack3, 2'b01);
    check("l3_rdat", rdat3, 16'h5A7A);
    req = 2'b00;
    step();
    check("l3_idle", busy3, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
